// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports, reservation
// and flush controls, and the scoreboard/status outputs.
//   master: drives addresses, write and reservation controls
//   slave : the register file; drives read data, busy flags and status
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_ok;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;
    logic                     wr_conflict;
    logic                     rsv_err;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, rsv_ok, busy_cnt, wr_conflict, rsv_err
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, rsv_ok, busy_cnt, wr_conflict, rsv_err
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read / dual-write register file with write-through bypass and a
// per-register busy scoreboard used for hazard stalls.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - regfile_mp_if.slave: read ports (combinational data/busy),
//          write port A (priority) and B, reserve/flush controls,
//          rsv_ok (combinational), busy_cnt / wr_conflict / rsv_err (registered)
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned NUM_REGS = 2**ADDR_W;
    localparam bit          ZR       = (ZERO_REG != 0);
    localparam bit          BP       = (BYPASS != 0);

    logic [DATA_W-1:0]       r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_busy;
    logic [ADDR_W:0]         r_busy_cnt;
    logic                    r_wr_conflict;
    logic                    r_rsv_err;

    logic                    w_same;
    logic                    w_wa_acc;
    logic                    w_wb_acc;
    logic                    w_conflict;
    logic                    w_rsv_ok;
    logic                    w_rsv_set;
    logic [NUM_REGS-1:0]     w_busy_nxt;
    logic [ADDR_W:0]         w_cnt_nxt;
    logic [ADDR_W-1:0]       w_ra;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]       w_rd_busy;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Write acceptance: A wins a same-address collision, zero reg drops writes
    always_comb begin
        w_same     = bus.wa_en && bus.wb_en && (bus.wa_addr == bus.wb_addr);
        w_wa_acc   = bus.wa_en && !is_zero(bus.wa_addr);
        w_wb_acc   = bus.wb_en && !is_zero(bus.wb_addr) && !w_same;
        w_conflict = w_same && !is_zero(bus.wa_addr);
        w_rsv_ok   = is_zero(bus.rsv_addr) || !r_busy[bus.rsv_addr];
        w_rsv_set  = bus.rsv_en && w_rsv_ok && !is_zero(bus.rsv_addr);
    end

    // Next busy vector: clears first so a same-edge reservation wins; flush overrides all
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wa_acc) w_busy_nxt[bus.wa_addr] = 1'b0;
        if (w_wb_acc) w_busy_nxt[bus.wb_addr] = 1'b0;
        if (w_rsv_set) w_busy_nxt[bus.rsv_addr] = 1'b1;
        if (bus.flush) w_busy_nxt = '0;
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
        end
    end

    // Combinational read ports with optional forwarding of this cycle's writes
    always_comb begin
        w_ra      = '0;
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (is_zero(w_ra)) begin
                w_rd_data[k*DATA_W +: DATA_W] = '0;
                w_rd_busy[k]                  = 1'b0;
            end else if (BP && w_wa_acc && (bus.wa_addr == w_ra)) begin
                w_rd_data[k*DATA_W +: DATA_W] = bus.wa_data;
                w_rd_busy[k]                  = 1'b0;
            end else if (BP && w_wb_acc && (bus.wb_addr == w_ra)) begin
                w_rd_data[k*DATA_W +: DATA_W] = bus.wb_data;
                w_rd_busy[k]                  = 1'b0;
            end else begin
                w_rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
                w_rd_busy[k]                  = r_busy[w_ra];
            end
        end
    end

    // Storage array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_wa_acc) r_regs[bus.wa_addr] <= bus.wa_data;
            if (w_wb_acc) r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= '0;
            r_busy_cnt    <= '0;
            r_wr_conflict <= 1'b0;
            r_rsv_err     <= 1'b0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_busy_cnt    <= w_cnt_nxt;
            r_wr_conflict <= w_conflict;
            r_rsv_err     <= bus.rsv_en && !w_rsv_ok;
        end
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.rd_busy     = w_rd_busy;
    assign bus.rsv_ok      = w_rsv_ok;
    assign bus.busy_cnt    = r_busy_cnt;
    assign bus.wr_conflict = r_wr_conflict;
    assign bus.rsv_err     = r_rsv_err;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one
// non-bypassing instance driven with identical stimulus.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wa_en, wb_en, rsv_en, flush;
    logic [3:0]  wa_addr, wb_addr, rsv_addr, ra0, ra1;
    logic [31:0] wa_data, wb_data;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) if0 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) if1 ();

    assign if0.rd_addr = {ra1, ra0};
    assign if0.wa_en = wa_en;   assign if0.wa_addr = wa_addr;   assign if0.wa_data = wa_data;
    assign if0.wb_en = wb_en;   assign if0.wb_addr = wb_addr;   assign if0.wb_data = wb_data;
    assign if0.rsv_en = rsv_en; assign if0.rsv_addr = rsv_addr; assign if0.flush = flush;
    assign if1.rd_addr = {ra1, ra0};
    assign if1.wa_en = wa_en;   assign if1.wa_addr = wa_addr;   assign if1.wa_data = wa_data;
    assign if1.wb_en = wb_en;   assign if1.wb_addr = wb_addr;   assign if1.wb_data = wb_data;
    assign if1.rsv_en = rsv_en; assign if1.rsv_addr = rsv_addr; assign if1.flush = flush;

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_bp (
        .clk(clk), .rst(rst), .bus(if0.slave));
    regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        logic        wa_en;  logic [3:0] wa_addr;  logic [31:0] wa_data;
        logic        wb_en;  logic [3:0] wb_addr;  logic [31:0] wb_data;
        logic        rsv_en; logic [3:0] rsv_addr; logic flush;
        logic [3:0]  ra0;    logic [3:0] ra1;
        logic [31:0] e_d0;   logic e_b0;
        logic [31:0] e_d1;   logic e_b1;
        logic [31:0] e_d1_nb;
        logic        e_ok;   logic [4:0] e_cnt; logic e_conf; logic e_err;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0;
        ra0 = 0; ra1 = 0;
    endtask

    initial begin
        //          wa_en,addr,data        wb_en,addr,data        rsv,addr,fl ra0,ra1 e_d0,b0              e_d1,b1             e_d1_nb       ok cnt cf er
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd7,0, 4'd3,4'd5, 32'h0,0,        32'h0,0,        32'h0,        1,5'd0,0,0});
        vecs.push_back('{1,4'd3,32'h11111111, 1,4'd3,32'h22222222, 0,4'd7,0, 4'd3,4'd0, 32'h11111111,0, 32'h0,0,        32'h0,        1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd7,0, 4'd3,4'd0, 32'h11111111,0, 32'h0,0,        32'h0,        1,5'd0,1,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd7,0, 4'd3,4'd0, 32'h11111111,0, 32'h0,0,        32'h0,        1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        1,4'd5,32'hDEADBEEF, 0,4'd7,0, 4'd3,4'd5, 32'h11111111,0, 32'hDEADBEEF,0, 32'h0,        1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd7,0, 4'd3,4'd5, 32'h11111111,0, 32'hDEADBEEF,0, 32'hDEADBEEF, 1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd7,0, 4'd7,4'd5, 32'h0,0,        32'hDEADBEEF,0, 32'hDEADBEEF, 1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd7,0, 4'd7,4'd5, 32'h0,1,        32'hDEADBEEF,0, 32'hDEADBEEF, 0,5'd1,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd7,0, 4'd7,4'd5, 32'h0,1,        32'hDEADBEEF,0, 32'hDEADBEEF, 0,5'd1,0,1});
        vecs.push_back('{1,4'd7,32'h77,       0,4'd0,32'h0,        0,4'd7,0, 4'd7,4'd5, 32'h77,0,       32'hDEADBEEF,0, 32'hDEADBEEF, 0,5'd1,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd7,0, 4'd7,4'd5, 32'h77,0,       32'hDEADBEEF,0, 32'hDEADBEEF, 1,5'd0,0,0});
        vecs.push_back('{1,4'd2,32'h22,       0,4'd0,32'h0,        1,4'd2,0, 4'd2,4'd7, 32'h22,0,       32'h77,0,       32'h77,       1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd2,0, 4'd2,4'd7, 32'h22,1,       32'h77,0,       32'h77,       0,5'd1,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd1,0, 4'd2,4'd7, 32'h22,1,       32'h77,0,       32'h77,       1,5'd1,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd4,0, 4'd4,4'd2, 32'h0,0,        32'h22,1,       32'h22,       1,5'd2,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd6,1, 4'd4,4'd2, 32'h0,1,        32'h22,1,       32'h22,       1,5'd3,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd6,0, 4'd6,4'd2, 32'h0,0,        32'h22,0,       32'h22,       1,5'd0,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd9,0, 4'd0,4'd2, 32'h0,0,        32'h22,0,       32'h22,       1,5'd0,0,0});
        vecs.push_back('{1,4'd0,32'hFFFFFFFF, 1,4'd0,32'h12345678, 1,4'd0,0, 4'd0,4'd9, 32'h0,0,        32'h0,1,        32'h0,        1,5'd1,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd0,0, 4'd0,4'd9, 32'h0,0,        32'h0,1,        32'h0,        1,5'd1,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        1,4'd10,0, 4'd9,4'd10, 32'h0,1,      32'h0,0,        32'h0,        1,5'd1,0,0});
        vecs.push_back('{1,4'd9,32'h9,        1,4'd10,32'hA,       0,4'd9,0, 4'd9,4'd10, 32'h9,0,       32'hA,0,        32'h0,        0,5'd2,0,0});
        vecs.push_back('{0,4'd0,32'h0,        0,4'd0,32'h0,        0,4'd9,0, 4'd9,4'd10, 32'h9,0,       32'hA,0,        32'hA,        1,5'd0,0,0});

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset cnt", 32'(if0.busy_cnt), 32'd0);
        chk("reset conf", 32'(if0.wr_conflict), 32'd0);
        chk("reset err", 32'(if0.rsv_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            wa_en = vecs[i].wa_en;   wa_addr = vecs[i].wa_addr;   wa_data = vecs[i].wa_data;
            wb_en = vecs[i].wb_en;   wb_addr = vecs[i].wb_addr;   wb_data = vecs[i].wb_data;
            rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr; flush = vecs[i].flush;
            ra0 = vecs[i].ra0;       ra1 = vecs[i].ra1;
            #1;
            chk($sformatf("v%0d rd0", i), if0.rd_data[31:0], vecs[i].e_d0);
            chk($sformatf("v%0d busy0", i), 32'(if0.rd_busy[0]), 32'(vecs[i].e_b0));
            chk($sformatf("v%0d rd1", i), if0.rd_data[63:32], vecs[i].e_d1);
            chk($sformatf("v%0d busy1", i), 32'(if0.rd_busy[1]), 32'(vecs[i].e_b1));
            chk($sformatf("v%0d nb rd1", i), if1.rd_data[63:32], vecs[i].e_d1_nb);
            chk($sformatf("v%0d rsv_ok", i), 32'(if0.rsv_ok), 32'(vecs[i].e_ok));
            chk($sformatf("v%0d busy_cnt", i), 32'(if0.busy_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d wr_conflict", i), 32'(if0.wr_conflict), 32'(vecs[i].e_conf));
            chk($sformatf("v%0d rsv_err", i), 32'(if0.rsv_err), 32'(vecs[i].e_err));
        end

        // Mid-run asynchronous reset with data stored and a register busy
        @(negedge clk);
        idle_inputs();
        rsv_en = 1; rsv_addr = 4'd11;
        @(negedge clk);
        idle_inputs();
        ra0 = 4'd3; ra1 = 4'd11;
        #1;
        chk("pre-rst cnt", 32'(if0.busy_cnt), 32'd1);
        chk("pre-rst rd0", if0.rd_data[31:0], 32'h11111111);
        chk("pre-rst busy1", 32'(if0.rd_busy[1]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst cnt", 32'(if0.busy_cnt), 32'd0);
        chk("async rst rd0", if0.rd_data[31:0], 32'h0);
        chk("async rst busy1", 32'(if0.rd_busy[1]), 32'd0);
        chk("async rst nb rd0", if1.rd_data[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post-rst rd0", if0.rd_data[31:0], 32'h0);
        chk("post-rst ok", 32'(if0.rsv_ok), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
